// File: rtl/usb_tx_pkg.sv
// Shared types for the USB TX packet scheduler: packet codes, handshake types,
// failure codes, scheduler states and the PID selection helpers.
package usb_tx_pkg;

    typedef enum logic [2:0] {
        PKT_NONE  = 3'd0,
        PKT_ACK   = 3'd1,
        PKT_NAK   = 3'd2,
        PKT_STALL = 3'd3,
        PKT_DATA0 = 3'd4,
        PKT_DATA1 = 3'd5
    } pkt_code_t;

    typedef enum logic [1:0] {
        HS_NONE  = 2'd0,
        HS_ACK   = 2'd1,
        HS_NAK   = 2'd2,
        HS_STALL = 2'd3
    } hs_type_t;

    typedef enum logic [1:0] {
        FAIL_NONE    = 2'd0,
        FAIL_BUFFER  = 2'd1,
        FAIL_TIMEOUT = 2'd2,
        FAIL_TX_ERR  = 2'd3
    } fail_code_t;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CHECK      = 3'd1,
        ST_ISSUE      = 3'd2,
        ST_WAIT_START = 3'd3,
        ST_ACTIVE     = 3'd4,
        ST_COOLDOWN   = 3'd5
    } sched_state_t;

    localparam int MAX_BYTES_DEFAULT = 64;

    function automatic pkt_code_t data_pid(input logic toggle);
        return toggle ? PKT_DATA1 : PKT_DATA0;
    endfunction

    function automatic pkt_code_t hs_pid(input hs_type_t t);
        case (t)
            HS_ACK:   return PKT_ACK;
            HS_NAK:   return PKT_NAK;
            HS_STALL: return PKT_STALL;
            default:  return PKT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/tx_req_latch.sv
// Holds pending handshake/data requests and picks the winner (handshake first).
// A new request arriving on the same edge as its own clear stays pending.
module tx_req_latch
    import usb_tx_pkg::*;
(
    input  logic       clk,
    input  logic       n_rst,
    input  logic       hs_req,
    input  logic [1:0] hs_type,
    input  logic       data_req,
    input  logic       hs_clear,
    input  logic       data_clear,
    output logic       sel_hs,
    output logic       sel_data,
    output hs_type_t   hs_type_q,
    output logic       pend_any_nxt
);

    logic     hs_pending_r;
    logic     data_pending_r;
    hs_type_t hs_type_r;
    logic     hs_set_s;
    logic     hs_pend_nxt_s;
    logic     data_pend_nxt_s;

    // Next-state of the pending flags; illegal handshake type is dropped here.
    always_comb begin
        hs_set_s        = 1'b0;
        hs_pend_nxt_s   = 1'b0;
        data_pend_nxt_s = 1'b0;
        if (hs_req && (hs_type != 2'd0)) begin
            hs_set_s = 1'b1;
        end else begin
            hs_set_s = 1'b0;
        end
        hs_pend_nxt_s   = hs_set_s | (hs_pending_r & ~hs_clear);
        data_pend_nxt_s = data_req | (data_pending_r & ~data_clear);
    end

    // Pending flag and handshake type registers (last handshake type wins).
    always_ff @(posedge clk) begin
        if (n_rst) begin
            hs_pending_r   <= 1'b0;
            data_pending_r <= 1'b0;
            hs_type_r      <= HS_NONE;
        end else begin
            hs_pending_r   <= hs_pend_nxt_s;
            data_pending_r <= data_pend_nxt_s;
            if (hs_set_s) begin
                hs_type_r <= hs_type_t'(hs_type);
            end
        end
    end

    assign sel_hs       = hs_pending_r;
    assign sel_data     = data_pending_r & ~hs_pending_r;
    assign hs_type_q    = hs_type_r;
    assign pend_any_nxt = hs_pend_nxt_s | data_pend_nxt_s;

endmodule

// File: rtl/tx_packet_scheduler.sv
// Sequences one TX packet at a time: arbitration, buffer check, single-cycle
// packet code issue, start/transfer supervision, inter-packet gap and DATA PID toggle.
module tx_packet_scheduler
    import usb_tx_pkg::*;
#(
    parameter int START_TIMEOUT = 16,
    parameter int IPG_CYCLES    = 8,
    parameter int MAX_BYTES     = MAX_BYTES_DEFAULT
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       hs_req,
    input  logic [1:0] hs_type,
    input  logic       data_req,
    input  logic       toggle_clear,
    input  logic [6:0] buffer_occupancy,
    input  logic       TX_transfer_active,
    input  logic       TX_err,
    output logic [2:0] TX_packet,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic [1:0] fail_code,
    output logic       data_toggle
);

    localparam int TO_W  = $clog2(START_TIMEOUT + 1);
    localparam int IPG_W = $clog2(IPG_CYCLES + 1);

    sched_state_t      state_r;
    pkt_code_t         tx_packet_r;
    fail_code_t        fail_code_r;
    logic              busy_r;
    logic              done_r;
    logic              fail_r;
    logic              toggle_r;
    logic              cur_is_data_r;
    logic [TO_W-1:0]   timeout_cnt_r;
    logic [IPG_W-1:0]  ipg_cnt_r;

    logic              sel_hs_s;
    logic              sel_data_s;
    hs_type_t          hs_type_q_s;
    logic              pend_any_nxt_s;
    logic              hs_clear_s;
    logic              data_clear_s;

    tx_req_latch u_req_latch (
        .clk          (clk),
        .n_rst        (n_rst),
        .hs_req       (hs_req),
        .hs_type      (hs_type),
        .data_req     (data_req),
        .hs_clear     (hs_clear_s),
        .data_clear   (data_clear_s),
        .sel_hs       (sel_hs_s),
        .sel_data     (sel_data_s),
        .hs_type_q    (hs_type_q_s),
        .pend_any_nxt (pend_any_nxt_s)
    );

    // A request is consumed on the edge the FSM leaves IDLE for it.
    always_comb begin
        hs_clear_s   = 1'b0;
        data_clear_s = 1'b0;
        if (state_r == ST_IDLE) begin
            hs_clear_s   = sel_hs_s;
            data_clear_s = sel_data_s;
        end else begin
            hs_clear_s   = 1'b0;
            data_clear_s = 1'b0;
        end
    end

    // Scheduler FSM with counters, toggle and registered outputs.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_r       <= ST_IDLE;
            tx_packet_r   <= PKT_NONE;
            fail_code_r   <= FAIL_NONE;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            fail_r        <= 1'b0;
            toggle_r      <= 1'b0;
            cur_is_data_r <= 1'b0;
            timeout_cnt_r <= '0;
            ipg_cnt_r     <= '0;
        end else begin
            tx_packet_r <= PKT_NONE;
            fail_code_r <= FAIL_NONE;
            done_r      <= 1'b0;
            fail_r      <= 1'b0;
            busy_r      <= 1'b1;
            case (state_r)
                ST_IDLE: begin
                    if (sel_hs_s) begin
                        state_r       <= ST_ISSUE;
                        tx_packet_r   <= hs_pid(hs_type_q_s);
                        cur_is_data_r <= 1'b0;
                    end else if (sel_data_s) begin
                        state_r       <= ST_CHECK;
                        cur_is_data_r <= 1'b1;
                    end else begin
                        busy_r <= pend_any_nxt_s;
                    end
                end
                ST_CHECK: begin
                    if ((buffer_occupancy == 7'd0) || (buffer_occupancy > 7'(MAX_BYTES))) begin
                        fail_r      <= 1'b1;
                        fail_code_r <= FAIL_BUFFER;
                        state_r     <= ST_IDLE;
                        busy_r      <= pend_any_nxt_s;
                    end else begin
                        state_r     <= ST_ISSUE;
                        tx_packet_r <= data_pid(toggle_r);
                    end
                end
                ST_ISSUE: begin
                    state_r       <= ST_WAIT_START;
                    timeout_cnt_r <= '0;
                end
                ST_WAIT_START: begin
                    if (TX_transfer_active) begin
                        state_r <= ST_ACTIVE;
                    end else if (TX_err) begin
                        fail_r      <= 1'b1;
                        fail_code_r <= FAIL_TX_ERR;
                        state_r     <= ST_COOLDOWN;
                        ipg_cnt_r   <= '0;
                    end else if (timeout_cnt_r >= TO_W'(START_TIMEOUT - 1)) begin
                        fail_r      <= 1'b1;
                        fail_code_r <= FAIL_TIMEOUT;
                        state_r     <= ST_COOLDOWN;
                        ipg_cnt_r   <= '0;
                    end else begin
                        timeout_cnt_r <= timeout_cnt_r + TO_W'(1);
                    end
                end
                ST_ACTIVE: begin
                    if (!TX_transfer_active) begin
                        if (TX_err) begin
                            fail_r      <= 1'b1;
                            fail_code_r <= FAIL_TX_ERR;
                        end else begin
                            done_r <= 1'b1;
                            if (cur_is_data_r) begin
                                toggle_r <= ~toggle_r;
                            end
                        end
                        state_r   <= ST_COOLDOWN;
                        ipg_cnt_r <= '0;
                    end
                end
                ST_COOLDOWN: begin
                    if (ipg_cnt_r >= IPG_W'(IPG_CYCLES - 1)) begin
                        state_r <= ST_IDLE;
                        busy_r  <= pend_any_nxt_s;
                    end else begin
                        ipg_cnt_r <= ipg_cnt_r + IPG_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= pend_any_nxt_s;
                end
            endcase
            // Clear takes precedence over a same-edge completion flip.
            if (toggle_clear) begin
                toggle_r <= 1'b0;
            end
        end
    end

    assign TX_packet   = tx_packet_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign fail        = fail_r;
    assign fail_code   = fail_code_r;
    assign data_toggle = toggle_r;

endmodule

// File: tb/tb_tx_packet_scheduler.sv
// Directed plus randomized bench for tx_packet_scheduler; expected timing and
// PIDs come from a transaction-level model (queue order, latencies, toggle bit).
module tb_tx_packet_scheduler;

    localparam int START_TIMEOUT = 16;
    localparam int IPG_CYCLES    = 8;
    localparam int MAX_BYTES     = 64;
    localparam int BEH_OK        = 0;
    localparam int BEH_ERR_END   = 1;
    localparam int BEH_ERR_START = 2;
    localparam int BEH_TIMEOUT   = 3;

    logic       tb_clk = 1'b0;
    logic       n_rst, hs_req, data_req, toggle_clear, TX_transfer_active, TX_err;
    logic [1:0] hs_type;
    logic [6:0] buffer_occupancy;
    logic [2:0] TX_packet;
    logic       busy, done, fail, data_toggle;
    logic [1:0] fail_code;

    int   n_cmp = 0;
    int   n_err = 0;
    logic model_toggle = 1'b0;

    always #5 tb_clk = ~tb_clk;

    tx_packet_scheduler #(
        .START_TIMEOUT (START_TIMEOUT),
        .IPG_CYCLES    (IPG_CYCLES),
        .MAX_BYTES     (MAX_BYTES)
    ) dut (
        .clk                (tb_clk),
        .n_rst              (n_rst),
        .hs_req             (hs_req),
        .hs_type            (hs_type),
        .data_req           (data_req),
        .toggle_clear       (toggle_clear),
        .buffer_occupancy   (buffer_occupancy),
        .TX_transfer_active (TX_transfer_active),
        .TX_err             (TX_err),
        .TX_packet          (TX_packet),
        .busy               (busy),
        .done               (done),
        .fail               (fail),
        .fail_code          (fail_code),
        .data_toggle        (data_toggle)
    );

    task automatic step();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit occ_ok(input logic [6:0] occ);
        return (occ != 7'd0) && (int'(occ) <= MAX_BYTES);
    endfunction

    task automatic wait_tx(input int exp_lat, input logic [2:0] exp_code);
        int cnt = 0;
        bit stray = 1'b0;
        do begin
            step();
            cnt++;
            if (done || fail) stray = 1'b1;
        end while (TX_packet == 3'd0 && cnt < 40);
        check("tx_latency", cnt, exp_lat);
        check("tx_code", TX_packet, exp_code);
        check("tx_stray_pulse", stray, 32'd0);
    endtask

    task automatic wait_outcome(input int exp_lat, input bit want_done, input logic [1:0] exp_code);
        int cnt = 0;
        do begin
            step();
            cnt++;
        end while (!done && !fail && cnt < 40);
        check("outcome_latency", cnt, exp_lat);
        check("outcome_done", done, want_done);
        check("outcome_fail", fail, !want_done);
        check("outcome_fail_code", fail_code, exp_code);
    endtask

    task automatic wait_idle(input int exp_lat);
        int cnt = 0;
        bit stray = 1'b0;
        while (busy && cnt < 40) begin
            step();
            cnt++;
            if (done || fail || TX_packet != 3'd0) stray = 1'b1;
        end
        check("busy_clear_latency", cnt, exp_lat);
        check("idle_stray", stray, 32'd0);
    endtask

    task automatic reject(input int exp_lat);
        int cnt = 0;
        bit tx_seen = 1'b0;
        do begin
            step();
            cnt++;
            if (TX_packet != 3'd0) tx_seen = 1'b1;
        end while (!fail && cnt < 40);
        check("reject_latency", cnt, exp_lat);
        check("reject_code", fail_code, 32'd1);
        check("reject_no_tx", tx_seen, 32'd0);
    endtask

    // Issue-to-outcome handling of one packet with a stubbed downstream.
    task automatic serve(input logic [2:0] code, input int lat, input int beh);
        int d   = $urandom_range(1, 12);
        int len = $urandom_range(1, 6);
        wait_tx(lat, code);
        step();
        check("tx_one_cycle", TX_packet, 32'd0);
        case (beh)
            BEH_TIMEOUT: wait_outcome(START_TIMEOUT, 1'b0, 2'd2);
            BEH_ERR_START: begin
                repeat (d - 1) step();
                TX_err = 1'b1;
                wait_outcome(1, 1'b0, 2'd3);
                TX_err = 1'b0;
            end
            default: begin
                repeat (d - 1) step();
                TX_transfer_active = 1'b1;
                repeat (len) step();
                TX_transfer_active = 1'b0;
                TX_err = (beh == BEH_ERR_END);
                wait_outcome(1, beh == BEH_OK, (beh == BEH_OK) ? 2'd0 : 2'd3);
                TX_err = 1'b0;
                if (beh == BEH_OK && code[2]) model_toggle = ~model_toggle;
            end
        endcase
    endtask

    // One transaction from idle: optional handshake and/or data request in the same cycle.
    task automatic xact(input bit do_hs, input logic [1:0] ht, input bit do_data,
                        input logic [6:0] occ, input int beh0, input int beh1);
        bit hs_live = do_hs && (ht != 2'd0);
        int lat = 2;
        buffer_occupancy = occ;
        hs_req   = do_hs;
        hs_type  = ht;
        data_req = do_data;
        step();
        hs_req   = 1'b0;
        data_req = 1'b0;
        if (!hs_live && !do_data) begin
            repeat (3) step();
            check("ignored_busy", busy, 32'd0);
            check("ignored_tx", TX_packet, 32'd0);
            return;
        end
        if (hs_live) begin
            serve({1'b0, ht}, 1, beh0);
            lat = IPG_CYCLES + 2;
        end
        if (do_data) begin
            if (occ_ok(occ)) begin
                serve(3'd4 + {2'b00, model_toggle}, lat, beh1);
                wait_idle(IPG_CYCLES);
            end else begin
                reject(lat);
                wait_idle(0);
            end
        end else begin
            wait_idle(IPG_CYCLES);
        end
        check("data_toggle", data_toggle, model_toggle);
    endtask

    task automatic pulse_toggle_clear();
        toggle_clear = 1'b1;
        step();
        toggle_clear = 1'b0;
        model_toggle = 1'b0;
        check("toggle_clear", data_toggle, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit         r_hs, r_data;
        logic [1:0] r_ht;
        logic [6:0] r_occ;
        n_rst = 1'b1; hs_req = 1'b0; data_req = 1'b0; toggle_clear = 1'b0;
        TX_transfer_active = 1'b0; TX_err = 1'b0; hs_type = 2'd0; buffer_occupancy = 7'd0;
        step();
        step();
        check("reset_outputs", {TX_packet, busy, done, fail, fail_code, data_toggle}, 32'd0);
        n_rst = 1'b0;

        xact(1'b1, 2'd1, 1'b0, 7'd0, BEH_OK, BEH_OK);          // ACK
        xact(1'b0, 2'd0, 1'b1, 7'd5, BEH_OK, BEH_OK);          // DATA0 -> toggle 1
        xact(1'b0, 2'd0, 1'b1, 7'd5, BEH_OK, BEH_OK);          // DATA1 -> toggle 0
        xact(1'b1, 2'd2, 1'b1, 7'd5, BEH_OK, BEH_OK);          // NAK beats data
        xact(1'b0, 2'd0, 1'b1, 7'd0, BEH_OK, BEH_OK);          // empty buffer
        xact(1'b0, 2'd0, 1'b1, 7'd65, BEH_OK, BEH_OK);         // oversize
        xact(1'b0, 2'd0, 1'b1, 7'd64, BEH_OK, BEH_OK);         // largest legal
        xact(1'b1, 2'd3, 1'b0, 7'd0, BEH_TIMEOUT, BEH_OK);
        xact(1'b0, 2'd0, 1'b1, 7'd10, BEH_OK, BEH_TIMEOUT);
        xact(1'b1, 2'd1, 1'b1, 7'd7, BEH_ERR_START, BEH_ERR_END);
        xact(1'b1, 2'd0, 1'b0, 7'd0, BEH_OK, BEH_OK);          // illegal type ignored
        xact(1'b0, 2'd0, 1'b1, 7'd1, BEH_OK, BEH_OK);
        pulse_toggle_clear();

        // Handshake type overwritten while pending: last one wins.
        buffer_occupancy = 7'd20;
        data_req = 1'b1;
        step();
        data_req = 1'b0;
        wait_tx(2, 3'd4 + {2'b00, model_toggle});
        step();
        check("tx_one_cycle", TX_packet, 32'd0);
        TX_transfer_active = 1'b1;
        hs_req = 1'b1; hs_type = 2'd1;
        step();
        hs_type = 2'd3;
        step();
        hs_req = 1'b0;
        step();
        TX_transfer_active = 1'b0;
        wait_outcome(1, 1'b1, 2'd0);
        model_toggle = ~model_toggle;
        serve(3'd3, IPG_CYCLES + 1, BEH_OK);
        wait_idle(IPG_CYCLES);
        check("data_toggle", data_toggle, model_toggle);
        pulse_toggle_clear();

        // toggle_clear coincident with a successful DATA0 completion.
        buffer_occupancy = 7'd3;
        data_req = 1'b1;
        step();
        data_req = 1'b0;
        wait_tx(2, 3'd4);
        step();
        TX_transfer_active = 1'b1;
        step();
        step();
        TX_transfer_active = 1'b0;
        toggle_clear = 1'b1;
        wait_outcome(1, 1'b1, 2'd0);
        toggle_clear = 1'b0;
        check("coincident_clear", data_toggle, 32'd0);
        wait_idle(IPG_CYCLES);

        // Reset in the middle of a DATA1 transfer.
        xact(1'b0, 2'd0, 1'b1, 7'd9, BEH_OK, BEH_OK);
        data_req = 1'b1;
        step();
        data_req = 1'b0;
        wait_tx(2, 3'd5);
        step();
        TX_transfer_active = 1'b1;
        step();
        step();
        n_rst = 1'b1;
        step();
        check("mid_reset_outputs", {TX_packet, busy, done, fail, fail_code, data_toggle}, 32'd0);
        n_rst = 1'b0;
        TX_transfer_active = 1'b0;
        model_toggle = 1'b0;
        repeat (4) step();
        check("post_reset_quiet", {TX_packet, busy, done, fail, fail_code, data_toggle}, 32'd0);

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) == 0) pulse_toggle_clear();
            r_hs   = 1'($urandom_range(0, 1));
            r_ht   = 2'($urandom_range(0, 3));
            r_data = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0:       r_occ = 7'd0;
                1:       r_occ = 7'd64;
                2:       r_occ = 7'($urandom_range(65, 127));
                default: r_occ = 7'($urandom_range(1, 64));
            endcase
            xact(r_hs, r_ht, r_data, r_occ, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
